// File: rtl/updown_counter_nd.sv
// updown_counter_nd: DIGITS cascaded modulo-MOD up/down counter with synchronous
// clear and parallel load, a one-cycle registered wrap flag, and a 7-segment
// decode per digit.
//
// Control handshake: there is no valid/ready handshake. Every input is sampled
// on each rising edge of cp, and the outputs reflect that edge one cycle later.
// The priority order is clr, then ld, then en; with none of them asserted the
// counter holds.
module updown_counter_nd #(
  parameter int DIGITS         = 2,
  parameter int MOD            = 10,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  cp,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  m,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   sin,
  output logic [4*DIGITS-1:0]   qout,
  output logic                  qcc,
  output logic [7*DIGITS-1:0]   led
);

  localparam logic [3:0] DIG_MAX = 4'(MOD - 1);
  localparam logic [4:0] DIG_MOD = 5'(MOD);
  localparam logic       SEG_INV = (SEG_ACTIVE_LOW != 0);

  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic                qcc_q, qcc_d;

  // Segment pattern {g,f,e,d,c,b,a} for one hex digit, active-high.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next-state logic: clear, load with clamping, or ripple count through the digits.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    cnt_d = cnt_q;
    qcc_d = 1'b0;
    carry = 1'b1;
    dig   = '0;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig = sin[4*k +: 4];
        // Out-of-range load digits become 0 so digits never exceed MOD-1.
        cnt_d[4*k +: 4] = ({1'b0, dig} >= DIG_MOD) ? 4'h0 : dig;
      end
    end else if (en) begin
      // carry means "every lower digit is at its terminal value", so this digit moves.
      for (int k = 0; k < DIGITS; k++) begin
        dig = cnt_q[4*k +: 4];
        if (carry) begin
          if (m) begin
            cnt_d[4*k +: 4] = (dig == DIG_MAX) ? 4'h0 : dig + 4'h1;
            carry           = (dig == DIG_MAX);
          end else begin
            cnt_d[4*k +: 4] = (dig == 4'h0) ? DIG_MAX : dig - 4'h1;
            carry           = (dig == 4'h0);
          end
        end
      end
      // Carry out of the top digit means the whole counter wrapped this edge.
      qcc_d = carry;
    end
  end

  // State registers with synchronous active-high clear.
  always_ff @(posedge cp) begin
    if (clr) begin
      cnt_q <= '0;
      qcc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      qcc_q <= qcc_d;
    end
  end

  // Per-digit 7-segment decode, optionally inverted for common-anode displays.
  always_comb begin
    led = '0;
    for (int k = 0; k < DIGITS; k++) begin
      led[7*k +: 7] = seg7(cnt_q[4*k +: 4]) ^ {7{SEG_INV}};
    end
  end

  assign qout = cnt_q;
  assign qcc  = qcc_q;

endmodule
